// File: rtl/control_sequencer_pkg.sv
// Shared opcode constants, step encoding and control-word layout for the
// sequencer, the datapath and the benches.
package control_sequencer_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ST_T0   = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_T4   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

  typedef struct packed {
    logic pc_out;
    logic ir_out;
    logic a_out;
    logic alu_out;
    logic ram_rd;
    logic mar_load;
    logic ir_load;
    logic a_load;
    logic b_load;
    logic out_load;
    logic flags_load;
    logic pc_load;
    logic pc_inc;
    logic ram_wr;
    logic alu_sub;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_IDLE = ctrl_word_t'(15'd0);

  // Instructions that need an operand memory access in T3.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
  endfunction

endpackage

// File: rtl/control_rom.sv
// Combinational micro-step decode: (step, opcode, flags, mem_ready) -> control word.
module control_rom
  import control_sequencer_pkg::*;
(
  input  logic [2:0]  state,
  input  logic [3:0]  opcode,
  input  logic        carry_flag,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output ctrl_word_t  ctrl
);

  // Control word for the current step; loads that complete a RAM access are gated by mem_ready.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      ST_T0: begin
        ctrl.pc_out   = 1'b1;
        ctrl.mar_load = 1'b1;
      end
      ST_T1: begin
        ctrl.ram_rd  = 1'b1;
        ctrl.ir_load = mem_ready;
        ctrl.pc_inc  = mem_ready;
      end
      ST_T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.ir_out   = 1'b1;
            ctrl.mar_load = 1'b1;
          end
          OP_LDI: begin
            ctrl.ir_out = 1'b1;
            ctrl.a_load = 1'b1;
          end
          OP_JMP: begin
            ctrl.ir_out  = 1'b1;
            ctrl.pc_load = 1'b1;
          end
          OP_JC: begin
            ctrl.ir_out  = 1'b1;
            ctrl.pc_load = carry_flag;
          end
          OP_JZ: begin
            ctrl.ir_out  = 1'b1;
            ctrl.pc_load = zero_flag;
          end
          OP_OUT: begin
            ctrl.a_out    = 1'b1;
            ctrl.out_load = 1'b1;
          end
          default: ctrl = CTRL_IDLE;
        endcase
      end
      ST_T3: begin
        case (opcode)
          OP_LDA: begin
            ctrl.ram_rd = 1'b1;
            ctrl.a_load = mem_ready;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_rd = 1'b1;
            ctrl.b_load = mem_ready;
          end
          OP_STA: begin
            ctrl.a_out  = 1'b1;
            ctrl.ram_wr = 1'b1;
          end
          default: ctrl = CTRL_IDLE;
        endcase
      end
      ST_T4: begin
        ctrl.alu_out    = 1'b1;
        ctrl.a_load     = 1'b1;
        ctrl.flags_load = 1'b1;
        ctrl.alu_sub    = (opcode == OP_SUB);
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Micro-step sequencer: step register and next-step logic, with control
// decode delegated to control_rom. clr=0 blanks every output immediately.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       pc_out,
  output logic       ir_out,
  output logic       a_out,
  output logic       alu_out,
  output logic       ram_rd,
  output logic       mar_load,
  output logic       ir_load,
  output logic       a_load,
  output logic       b_load,
  output logic       out_load,
  output logic       flags_load,
  output logic       pc_load,
  output logic       pc_inc,
  output logic       ram_wr,
  output logic       alu_sub,
  output logic [2:0] t_state,
  output logic       halted
);

  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  ctrl_word_t rom_ctrl_s;
  ctrl_word_t ctrl_s;

  control_rom u_control_rom (
    .state      (state_r),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .mem_ready  (mem_ready),
    .ctrl       (rom_ctrl_s)
  );

  // Step register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= ST_T0;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next step; T1 and T3 stall until the RAM handshake completes.
  always_comb begin
    state_nxt_s = ST_T0;
    case (state_r)
      ST_T0: state_nxt_s = ST_T1;
      ST_T1: state_nxt_s = mem_ready ? ST_T2 : ST_T1;
      ST_T2: begin
        if (is_mem_op(opcode)) begin
          state_nxt_s = ST_T3;
        end else if (opcode == OP_HLT) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_T0;
        end
      end
      ST_T3: begin
        if (!mem_ready) begin
          state_nxt_s = ST_T3;
        end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
          state_nxt_s = ST_T4;
        end else begin
          state_nxt_s = ST_T0;
        end
      end
      ST_T4:   state_nxt_s = ST_T0;
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_T0;
    endcase
  end

  // Reset blanks the control word combinationally, ahead of the async flop.
  always_comb begin
    if (clr) begin
      ctrl_s = rom_ctrl_s;
    end else begin
      ctrl_s = CTRL_IDLE;
    end
  end

  assign pc_out     = ctrl_s.pc_out;
  assign ir_out     = ctrl_s.ir_out;
  assign a_out      = ctrl_s.a_out;
  assign alu_out    = ctrl_s.alu_out;
  assign ram_rd     = ctrl_s.ram_rd;
  assign mar_load   = ctrl_s.mar_load;
  assign ir_load    = ctrl_s.ir_load;
  assign a_load     = ctrl_s.a_load;
  assign b_load     = ctrl_s.b_load;
  assign out_load   = ctrl_s.out_load;
  assign flags_load = ctrl_s.flags_load;
  assign pc_load    = ctrl_s.pc_load;
  assign pc_inc     = ctrl_s.pc_inc;
  assign ram_wr     = ctrl_s.ram_wr;
  assign alu_sub    = ctrl_s.alu_sub;

  assign halted  = clr && (state_r == ST_HALT);
  assign t_state = (!clr || (state_r == ST_HALT)) ? 3'd0 : state_r;

endmodule
